// File: rtl/load_unit.sv
// load_unit: issues a word read over a strobe/ack handshake, extracts and extends byte/half/word loads.
// Optional MISALIGNED_SPLIT_EN: misaligned LH/LW are served by two consecutive word reads.
module load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        ld_fault,
  output logic        stall
);
  localparam logic [1:0] IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, DONE = 2'd3;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic [1:0]  r_state;
  logic [31:0] r_addr, r_lo, r_data, r_cnt;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_fault;
  logic        w_accept, w_in_bad, w_r_mis, w_tmo;
  logic [63:0] w_cat;
  logic [31:0] w_word, w_ext, w_base;

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] sz);
    return (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction

  assign req_ready = (r_state == IDLE) & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign stall     = r_state != IDLE;
  assign mem_rd    = (r_state == RD0) | (r_state == RD1);
  assign w_base    = {r_addr[31:2], 2'b00};
  assign mem_addr  = r_state == RD0 ? w_base : r_state == RD1 ? w_base + 32'd4 : 32'h0;
  assign ld_valid  = r_state == DONE;
  assign ld_data   = r_data;
  assign ld_rd     = r_rd;
  assign ld_fault  = r_fault;
  assign w_in_bad  = (&funct3[1:0]) | (funct3[2] & funct3[1]) | (~SPLIT & misaligned(addr[1:0], funct3[1:0]));
  assign w_r_mis   = misaligned(r_addr[1:0], r_f3[1:0]);
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES - 1));
  // Aligning the byte offset to bit 0 serves both the single-word and the split {hi,lo} case.
  assign w_cat     = r_state == RD1 ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
  assign w_word    = 32'(w_cat >> {r_addr[1:0], 3'b000});
  assign w_ext     = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_word[7]}}, w_word[7:0]} :
                     r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_word[15]}}, w_word[15:0]} : w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_lo    <= '0;
      r_data  <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_addr  <= addr;
        r_f3    <= funct3;
        r_rd    <= rd_in;
        r_cnt   <= '0;
        r_data  <= '0;
        r_fault <= w_in_bad;
        r_state <= w_in_bad ? DONE : RD0;
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end else if (mem_ack) begin
      r_lo  <= mem_rdata;
      r_cnt <= '0;
      if (r_state == RD0 && SPLIT && w_r_mis) begin
        r_state <= RD1;
      end else begin
        r_state <= DONE;
        r_data  <= w_ext;
        r_fault <= 1'b0;
      end
    end else if (w_tmo) begin
      r_state <= DONE;
      r_data  <= '0;
      r_fault <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table vectors, randomized loads against a byte-level reference model, and a mid-access reset.
module tb_load_unit;
  localparam int T = 4;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic        clk = 0, rst = 1, req_valid = 0, mem_ack = 0;
  logic        req_ready, mem_rd, ld_valid, ld_fault, stall;
  logic [31:0] addr = 0, mem_rdata = 0, mem_addr, ld_data;
  logic [2:0]  funct3 = 0;
  logic [4:0]  rd_in = 0, ld_rd;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] lo, hi;
    int          dly;
    logic [31:0] exp_d;
    logic        exp_f;
    int          exp_nrd;
  } vec_t;
  vec_t tv[15];

  load_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .funct3(funct3), .rd_in(rd_in), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .ld_fault(ld_fault), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic void model(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] lo, hi,
                                input int dly, output logic [31:0] d, output logic f, output int nrd);
    int size = 1 << f3[1:0];
    int off = int'(a[1:0]);
    int reads;
    logic [7:0] b[8];
    longint v = 0;
    d = 0; f = 0; nrd = 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin f = 1; return; end
    reads = (off % size != 0) ? (SPLIT ? 2 : 0) : 1;
    if (reads == 0) begin f = 1; return; end
    for (int i = 0; i < reads; i++) begin
      if (dly >= T) begin nrd += T; f = 1; return; end
      nrd += dly + 1;
    end
    for (int i = 0; i < 4; i++) begin b[i] = lo[8*i +: 8]; b[i+4] = hi[8*i +: 8]; end
    for (int i = 0; i < size; i++) v += longint'(b[off+i]) << (8*i);
    if (!f3[2] && size < 4 && v >= (64'sd1 << (8*size-1))) v -= (64'sd1 << (8*size));
    d = 32'(v);
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the ld_valid cycle.
  task automatic apply(input string tag, input vec_t v);
    int k = 0, nack = 0, nrd = 0, lat = 0;
    bit prd = 0, pack = 0, busy_ok, addr_ok = 1, done = 0;
    logic [31:0] d = 0;
    logic f = 0;
    logic [4:0] r = 0;
    busy_ok = req_ready;
    req_valid = 1; addr = v.a; funct3 = v.f3; rd_in = v.rd; mem_ack = 1; mem_rdata = $urandom;
    @(negedge clk);
    req_valid = 0; addr = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    for (int c = 0; c < 40 && !done; c++) begin
      lat++;
      if (ld_valid) begin
        done = 1; d = ld_data; f = ld_fault; r = ld_rd;
      end else begin
        busy_ok &= stall & ~req_ready;
        mem_ack = 0;
        if (mem_rd) begin
          k = (!prd || pack) ? 0 : k + 1;
          addr_ok &= mem_addr == ({v.a[31:2], 2'b00} + 32'(4 * nack));
          nrd++;
          mem_ack = (k == v.dly);
          mem_rdata = nack == 0 ? v.lo : v.hi;
          if (mem_ack) nack++;
        end else begin
          mem_ack = 1'($urandom);
          mem_rdata = $urandom;
        end
        prd = mem_rd; pack = mem_ack;
        @(negedge clk);
      end
    end
    mem_ack = 0;
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " data"}, d, v.exp_d);
    chk({tag, " fault"}, 32'(f), 32'(v.exp_f));
    chk({tag, " rd"}, 32'(r), 32'(v.rd));
    chk({tag, " mem_rd cycles"}, nrd, v.exp_nrd);
    chk({tag, " latency"}, lat, nrd + 1);
    chk({tag, " busy"}, 32'(busy_ok), 1);
    chk({tag, " mem_addr"}, 32'(addr_ok), 1);
    if (done) @(negedge clk);
    chk({tag, " pulse"}, {30'd0, ld_valid, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    bit seen;
    tv[0]  = '{32'h103, 3'b000, 5'd1,  32'h80FF1234, 32'h0, 0, 32'hFFFFFF80, 1'b0, 1};
    tv[1]  = '{32'h202, 3'b101, 5'd2,  32'hBEEF0000, 32'h0, 3, 32'h0000BEEF, 1'b0, 4};
    tv[2]  = '{32'h101, 3'b010, 5'd3,  32'h44332211, 32'h88776655, 0, SPLIT ? 32'h55443322 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    tv[3]  = '{32'h102, 3'b010, 5'd4,  32'h44332211, 32'h88776655, 0, SPLIT ? 32'h66554433 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    tv[4]  = '{32'h100, 3'b000, 5'd5,  32'h1234567F, 32'h0, 1, 32'h0000007F, 1'b0, 2};
    tv[5]  = '{32'h102, 3'b001, 5'd6,  32'h80010000, 32'h0, 0, 32'hFFFF8001, 1'b0, 1};
    tv[6]  = '{32'h003, 3'b100, 5'd7,  32'hAB000000, 32'h0, 2, 32'h000000AB, 1'b0, 3};
    tv[7]  = '{32'h200, 3'b010, 5'd8,  32'hDEADBEEF, 32'h0, 2, 32'hDEADBEEF, 1'b0, 3};
    tv[8]  = '{32'h100, 3'b011, 5'd9,  32'h11111111, 32'h0, 0, 32'h0, 1'b1, 0};
    tv[9]  = '{32'h100, 3'b110, 5'd10, 32'h22222222, 32'h0, 0, 32'h0, 1'b1, 0};
    tv[10] = '{32'h100, 3'b111, 5'd11, 32'h33333333, 32'h0, 0, 32'h0, 1'b1, 0};
    tv[11] = '{32'h300, 3'b010, 5'd12, 32'h55555555, 32'h0, 99, 32'h0, 1'b1, T};
    tv[12] = '{32'h201, 3'b101, 5'd13, 32'h44332211, 32'h88776655, 0, SPLIT ? 32'h3322 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    tv[13] = '{32'h1FE, 3'b001, 5'd14, 32'h7FFF0000, 32'h0, 1, 32'h00007FFF, 1'b0, 2};
    tv[14] = '{32'hFFFFFFFF, 3'b010, 5'd15, 32'h44332211, 32'h88776655, 0, SPLIT ? 32'h77665544 : 32'h0, !SPLIT, SPLIT ? 2 : 0};
    repeat (2) @(negedge clk);
    chk("reset outs", {req_ready, mem_rd, ld_valid, ld_fault, stall}, 5'b0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset ld_data", ld_data, 0);
    chk("reset ld_rd", 32'(ld_rd), 0);
    rst = 0;
    @(negedge clk);
    chk("idle ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), tv[i]);
    for (int i = 0; i < 150; i++) begin
      v.a = $urandom;
      v.f3 = 3'($urandom);
      v.rd = 5'($urandom);
      v.lo = $urandom;
      v.hi = $urandom;
      v.dly = $urandom_range(0, T + 1);
      model(v.a, v.f3, v.lo, v.hi, v.dly, v.exp_d, v.exp_f, v.exp_nrd);
      apply($sformatf("rnd%0d", i), v);
    end
    req_valid = 1; addr = 32'h400; funct3 = 3'b010; rd_in = 5'd9;
    @(negedge clk);
    req_valid = 0;
    chk("rd0 mem_rd", {31'd0, mem_rd}, 1);
    rst = 1;
    #1;
    chk("rst mid-read outs", {mem_rd, stall, req_ready, ld_valid}, 4'b0);
    chk("rst mid-read mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= ld_valid; end
    chk("no ld_valid after rst", 32'(seen), 0);
    apply("post-rst", tv[0]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
